// File: rtl/stack_pkg.sv
// Shared definitions for the stack arbiter slice: parameter defaults, op codes,
// FSM state encoding and the round-robin pointer helper.
// Latency: n/a (package only). Backpressure: n/a.
package stack_pkg;

  localparam int NREQ_DEF = 4;
  localparam int DW_DEF   = 8;

  // Requester op encoding on req_op
  localparam logic OP_PUSH = 1'b0;
  localparam logic OP_POP  = 1'b1;

  // Arbiter FSM state encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  // Next round-robin start position after granting requester w out of n.
  function automatic int rr_next(input int w, input int n);
    return (w + 1 >= n) ? 0 : w + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin priority pick: first requester at or after ptr (wrapping) wins.
// Latency: purely combinational, no state; the pointer register lives in the caller.
// Backpressure: none; the caller decides when to act on the grant.
// Ports:
//   req  in  NREQ  request vector
//   ptr  in  IW    highest-priority index this cycle
//   gnt  out NREQ  one-hot grant (zero when no request)
//   idx  out IW    binary index of the grant (zero when no request)
//   any  out 1     at least one request present
module rr_arbiter
  import stack_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx,
  output logic            any
);

  // One extra bit so ptr+i can exceed NREQ-1 before the wrap subtraction.
  logic [IW:0] cand;
  logic        found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = {1'b0, ptr} + (IW+1)'(i);
      if (cand >= (IW+1)'(NREQ)) begin
        cand = cand - (IW+1)'(NREQ);
      end
      if (!found && req[cand[IW-1:0]]) begin
        found               = 1'b1;
        gnt[cand[IW-1:0]]   = 1'b1;
        idx                 = cand[IW-1:0];
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/stack_arbiter.sv
// Shares one LIFO stack among NREQ requesters, one push/pop in flight at a time.
// Latency from request in IDLE: push rsp +2, pop rsp +3, rejected op rsp +2.
// Backpressure: requesters hold their request until req_ready; full/empty ops are
// rejected with rsp_err rather than stalled.
// Ports:
//   clk, rst                  clock, async active-high reset
//   req_valid/req_op/req_wdata per-requester request (op 0=push, 1=pop), data slice i*DW
//   req_ready                 one-hot accept pulse
//   rsp_valid/rsp_err/rsp_rdata one-hot response pulse, reject flag, pop data (held)
//   stk_push/stk_pop/stk_din  stack strobes and write data (this block is sole driver)
//   stk_dout/stk_empty/stk_full stack read data (1 cycle after pop) and flags
module stack_arbiter
  import stack_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int DW   = DW_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req_valid,
  input  logic [NREQ-1:0]  req_op,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]  req_ready,
  output logic [NREQ-1:0]  rsp_valid,
  output logic             rsp_err,
  output logic [DW-1:0]    rsp_rdata,
  output logic             stk_push,
  output logic             stk_pop,
  output logic [DW-1:0]    stk_din,
  input  logic [DW-1:0]    stk_dout,
  input  logic             stk_empty,
  input  logic             stk_full
);

  localparam int IW = $clog2(NREQ);

  logic [1:0]      state;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   win;
  logic            op_q;
  logic [DW-1:0]   wdata_q;
  logic            legal_q;

  logic [NREQ-1:0] gnt;
  logic [IW-1:0]   gnt_idx;
  logic            req_any;

  logic            op_sel;
  logic [DW-1:0]   wdata_sel;
  logic            legal_sel;
  logic [NREQ-1:0] win_oh;

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr (
    .req (req_valid),
    .ptr (rr_ptr),
    .gnt (gnt),
    .idx (gnt_idx),
    .any (req_any)
  );

  // Mux the winner's op and data with the one-hot grant.
  always_comb begin
    wdata_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        wdata_sel = req_wdata[i*DW +: DW];
      end
    end
  end

  assign op_sel = |(req_op & gnt);

  // Legality is decided from the flags seen in IDLE; nothing else moves the
  // stack while an op is in flight, so the flags cannot go stale.
  assign legal_sel = (op_sel == OP_POP) ? ~stk_empty : ~stk_full;

  assign win_oh = NREQ'(1) << win;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      rr_ptr    <= '0;
      win       <= '0;
      op_q      <= OP_PUSH;
      wdata_q   <= '0;
      legal_q   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_any) begin
            win     <= gnt_idx;
            op_q    <= op_sel;
            wdata_q <= wdata_sel;
            legal_q <= legal_sel;
            // Pointer moves on every grant, rejections included, for fairness.
            rr_ptr  <= IW'(rr_next(int'(gnt_idx), NREQ));
            state   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          state <= (op_q == OP_POP && legal_q) ? ST_WAIT : ST_RESP;
        end
        ST_WAIT: begin
          // Stack read data is registered, so it is valid in the cycle after the pop strobe.
          rsp_rdata <= stk_dout;
          state     <= ST_RESP;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Output decode is purely from state registers: no input-to-output paths.
  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    rsp_err   = 1'b0;
    stk_push  = 1'b0;
    stk_pop   = 1'b0;
    stk_din   = '0;
    case (state)
      ST_ISSUE: begin
        req_ready = win_oh;
        if (legal_q) begin
          stk_push = (op_q == OP_PUSH);
          stk_pop  = (op_q == OP_POP);
          stk_din  = wdata_q;
        end
      end
      ST_RESP: begin
        rsp_valid = win_oh;
        rsp_err   = ~legal_q;
      end
      default: begin
      end
    endcase
  end

endmodule
